// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU instruction sequencer:
// control-step states, opcode classes and IR field positions.
package alu_seq_pkg;

  localparam int unsigned NUM_REGS_DEF   = 16;
  localparam int unsigned REG_ADDR_W_DEF = 4;
  localparam int unsigned OP_W_DEF       = 5;

  localparam int unsigned OPC_LSB = 27;
  localparam int unsigned RA_LSB  = 23;
  localparam int unsigned RB_LSB  = 19;
  localparam int unsigned RC_LSB  = 15;

  localparam int unsigned OP_ROL = 8;
  localparam int unsigned OP_MUL = 15;
  localparam int unsigned OP_DIV = 16;
  localparam int unsigned OP_NEG = 17;
  localparam int unsigned OP_NOT = 18;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T1W, S_T2, S_T3, S_T4, S_T5, S_T6
  } state_t;

  typedef enum logic [1:0] {
    CLS_BINARY, CLS_WIDE, CLS_UNARY, CLS_ILLEGAL
  } op_class_t;

  // ADD..ROL are contiguous from zero, so a single upper bound covers them.
  function automatic op_class_t op_class(input int unsigned op);
    if (op <= OP_ROL) return CLS_BINARY;
    if (op == OP_MUL || op == OP_DIV) return CLS_WIDE;
    if (op == OP_NEG || op == OP_NOT) return CLS_UNARY;
    return CLS_ILLEGAL;
  endfunction

endpackage

// File: rtl/alu_instr_sequencer_reg_select_decoder.sv
// Register index to one-hot select; the range flag ignores the enable so it
// can feed the legality decision that in turn gates the enable.
module reg_select_decoder import alu_seq_pkg::*; #(
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter int unsigned ADDR_W   = REG_ADDR_W_DEF
) (
  input  logic                en,
  input  logic [ADDR_W-1:0]   idx,
  output logic [NUM_REGS-1:0] onehot,
  output logic                oor
);

  assign oor    = 32'(idx) >= NUM_REGS;
  assign onehot = (en && !oor) ? (NUM_REGS'(1) << idx) : '0;

endmodule

// File: rtl/alu_instr_sequencer.sv
// Fetch/execute control-step sequencer for register-format ALU instructions.
// Controls are a Moore decode of the step state plus IR fields.
module alu_instr_sequencer import alu_seq_pkg::*; #(
  parameter int unsigned NUM_REGS   = NUM_REGS_DEF,
  parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int unsigned OP_W       = OP_W_DEF
) (
  input  logic                Clock,
  input  logic                clear,
  input  logic                start,
  input  logic                mem_ready,
  input  logic [31:0]         ir_data,
  output logic                pc_out,
  output logic                zlow_out,
  output logic                zhigh_out,
  output logic                mdr_out,
  output logic                mar_in,
  output logic                pc_in,
  output logic                mdr_in,
  output logic                ir_in,
  output logic                y_in,
  output logic                z_in,
  output logic                lo_in,
  output logic                hi_in,
  output logic                inc_pc,
  output logic                read,
  output logic [NUM_REGS-1:0] reg_out,
  output logic [NUM_REGS-1:0] reg_in,
  output logic [OP_W-1:0]     alu_op,
  output logic                busy,
  output logic                done,
  output logic                illegal
);

  state_t state, state_nxt;

  logic [OP_W-1:0]       opcode;
  logic [REG_ADDR_W-1:0] ra, rb, rc, src_idx;
  op_class_t             cls;
  logic                  src_en, ld_en, src_oor, ld_oor, rc_oor, legal;
  logic                  unused_bits;

  assign opcode      = ir_data[OPC_LSB +: OP_W];
  assign ra          = ir_data[RA_LSB +: REG_ADDR_W];
  assign rb          = ir_data[RB_LSB +: REG_ADDR_W];
  assign rc          = ir_data[RC_LSB +: REG_ADDR_W];
  assign unused_bits = ^ir_data[RC_LSB-1:0];
  assign cls         = op_class(32'(opcode));
  assign rc_oor      = 32'(rc) >= NUM_REGS;

  // Legality is only consulted in T3, where the source decoder is looking at Rb.
  assign legal = (cls != CLS_ILLEGAL) && !src_oor
              && !((cls != CLS_WIDE) && ld_oor)
              && !((cls != CLS_UNARY) && rc_oor);

  reg_select_decoder #(.NUM_REGS(NUM_REGS), .ADDR_W(REG_ADDR_W)) u_src_sel (
    .en(src_en), .idx(src_idx), .onehot(reg_out), .oor(src_oor)
  );

  reg_select_decoder #(.NUM_REGS(NUM_REGS), .ADDR_W(REG_ADDR_W)) u_ld_sel (
    .en(ld_en), .idx(ra), .onehot(reg_in), .oor(ld_oor)
  );

  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-step and control decode.
  always_comb begin
    state_nxt = state;
    pc_out = 1'b0; zlow_out = 1'b0; zhigh_out = 1'b0; mdr_out = 1'b0;
    mar_in = 1'b0; pc_in = 1'b0; mdr_in = 1'b0; ir_in = 1'b0;
    y_in = 1'b0; z_in = 1'b0; lo_in = 1'b0; hi_in = 1'b0;
    inc_pc = 1'b0; read = 1'b0;
    alu_op = '0; src_en = 1'b0; src_idx = rb; ld_en = 1'b0;
    done = 1'b0; illegal = 1'b0;
    busy = (state != S_IDLE);
    unique case (state)
      S_IDLE: if (start) state_nxt = S_T0;
      S_T0: begin
        pc_out = 1'b1; mar_in = 1'b1; inc_pc = 1'b1; z_in = 1'b1;
        state_nxt = S_T1;
      end
      S_T1: begin
        zlow_out = 1'b1; pc_in = 1'b1;
        state_nxt = S_T1W;
      end
      S_T1W: begin
        read = 1'b1; mdr_in = 1'b1;
        if (mem_ready) state_nxt = S_T2;
      end
      S_T2: begin
        mdr_out = 1'b1; ir_in = 1'b1;
        state_nxt = S_T3;
      end
      S_T3: begin
        if (!legal) begin
          illegal   = 1'b1;
          state_nxt = S_IDLE;
        end else if (cls == CLS_UNARY) begin
          src_en = 1'b1; alu_op = opcode; z_in = 1'b1;
          state_nxt = S_T5;
        end else begin
          src_en = 1'b1; y_in = 1'b1;
          state_nxt = S_T4;
        end
      end
      S_T4: begin
        src_en = 1'b1; src_idx = rc; alu_op = opcode; z_in = 1'b1;
        state_nxt = S_T5;
      end
      S_T5: begin
        zlow_out = 1'b1;
        if (cls == CLS_WIDE) begin
          lo_in     = 1'b1;
          state_nxt = S_T6;
        end else begin
          ld_en     = 1'b1;
          done      = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_T6: begin
        zhigh_out = 1'b1; hi_in = 1'b1; done = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Self-checking bench for alu_instr_sequencer: directed vector table with
// per-instruction summaries, randomized instructions against a step-trace model,
// and an asynchronous clear mid-instruction.
module tb_alu_instr_sequencer;

  typedef struct packed {
    logic [13:0] ctl;
    logic [15:0] ro;
    logic [15:0] ri;
    logic [4:0]  op;
    logic        busy;
    logic        done;
    logic        ill;
  } obs_t;

  typedef struct {
    logic [31:0] ir;
    int          w;
    int          done_at;
    int          ill_at;
    logic [15:0] ro;
    logic [15:0] ri;
    logic [4:0]  op;
    int          n_read;
    int          n_pc_in;
    int          n_lo;
    int          n_hi;
  } vec_t;

  // Control bit masks in the order {pc_out .. read} of the observation vector.
  localparam logic [13:0] M_PC_OUT = 14'h2000, M_ZLOW  = 14'h1000, M_ZHIGH = 14'h0800;
  localparam logic [13:0] M_MDROUT = 14'h0400, M_MARIN = 14'h0200, M_PCIN  = 14'h0100;
  localparam logic [13:0] M_MDRIN  = 14'h0080, M_IRIN  = 14'h0040, M_YIN   = 14'h0020;
  localparam logic [13:0] M_ZIN    = 14'h0010, M_LOIN  = 14'h0008, M_HIIN  = 14'h0004;
  localparam logic [13:0] M_INCPC  = 14'h0002, M_READ  = 14'h0001;

  logic        Clock = 1'b0;
  logic        clear, start, mem_ready;
  logic [31:0] ir_data;
  logic pc_out, zlow_out, zhigh_out, mdr_out, mar_in, pc_in, mdr_in, ir_in;
  logic y_in, z_in, lo_in, hi_in, inc_pc, read, busy, done, illegal;
  logic [15:0] reg_out, reg_in;
  logic [4:0]  alu_op;

  obs_t cur;
  obs_t exp_q[$];
  int   n_total = 0;
  int   n_bad = 0;

  int          a_done_at, a_ill_at, a_read, a_pc_in, a_lo, a_hi;
  logic [15:0] a_ro, a_ri;
  logic [4:0]  a_op;

  vec_t vt[9];

  alu_instr_sequencer dut (
    .Clock(Clock), .clear(clear), .start(start), .mem_ready(mem_ready), .ir_data(ir_data),
    .pc_out(pc_out), .zlow_out(zlow_out), .zhigh_out(zhigh_out), .mdr_out(mdr_out),
    .mar_in(mar_in), .pc_in(pc_in), .mdr_in(mdr_in), .ir_in(ir_in), .y_in(y_in),
    .z_in(z_in), .lo_in(lo_in), .hi_in(hi_in), .inc_pc(inc_pc), .read(read),
    .reg_out(reg_out), .reg_in(reg_in), .alu_op(alu_op), .busy(busy), .done(done),
    .illegal(illegal)
  );

  always #5 Clock = ~Clock;

  assign cur = {pc_out, zlow_out, zhigh_out, mdr_out, mar_in, pc_in, mdr_in, ir_in,
                y_in, z_in, lo_in, hi_in, inc_pc, read, reg_out, reg_in, alu_op,
                busy, done, illegal};

  function automatic obs_t mk(input logic [13:0] c, input logic [15:0] ro,
                              input logic [15:0] ri, input logic [4:0] op,
                              input logic dn, input logic il);
    obs_t o;
    o.ctl = c; o.ro = ro; o.ri = ri; o.op = op;
    o.busy = 1'b1; o.done = dn; o.ill = il;
    return o;
  endfunction

  function automatic logic [15:0] oh(input int i);
    return 16'(1) << i;
  endfunction

  // Expected per-cycle controls from T0 to the last busy step.
  task automatic build_trace(input logic [31:0] ir, input int w);
    int op, ra, rb, rc;
    op = int'(ir[31:27]); ra = int'(ir[26:23]); rb = int'(ir[22:19]); rc = int'(ir[18:15]);
    exp_q.delete();
    exp_q.push_back(mk(M_PC_OUT | M_MARIN | M_INCPC | M_ZIN, 0, 0, 0, 0, 0));
    exp_q.push_back(mk(M_ZLOW | M_PCIN, 0, 0, 0, 0, 0));
    for (int k = 0; k <= w; k++) exp_q.push_back(mk(M_READ | M_MDRIN, 0, 0, 0, 0, 0));
    exp_q.push_back(mk(M_MDROUT | M_IRIN, 0, 0, 0, 0, 0));
    if (op <= 8) begin
      exp_q.push_back(mk(M_YIN, oh(rb), 0, 0, 0, 0));
      exp_q.push_back(mk(M_ZIN, oh(rc), 0, 5'(op), 0, 0));
      exp_q.push_back(mk(M_ZLOW, 0, oh(ra), 0, 1, 0));
    end else if (op == 15 || op == 16) begin
      exp_q.push_back(mk(M_YIN, oh(rb), 0, 0, 0, 0));
      exp_q.push_back(mk(M_ZIN, oh(rc), 0, 5'(op), 0, 0));
      exp_q.push_back(mk(M_ZLOW | M_LOIN, 0, 0, 0, 0, 0));
      exp_q.push_back(mk(M_ZHIGH | M_HIIN, 0, 0, 0, 1, 0));
    end else if (op == 17 || op == 18) begin
      exp_q.push_back(mk(M_ZIN, oh(rb), 0, 5'(op), 0, 0));
      exp_q.push_back(mk(M_ZLOW, 0, oh(ra), 0, 1, 0));
    end else begin
      exp_q.push_back(mk('0, 0, 0, 0, 0, 1));
    end
  endtask

  task automatic check_obs(input string name, input int cyc, input obs_t got, input obs_t want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
    end
  endtask

  task automatic check_int(input string name, input int idx, input int got, input int want);
    n_total++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s vec=%0d got=%0h want=%0h", name, idx, got, want);
    end
  endtask

  // One cycle of an instruction: drive, sample, accumulate, advance.
  // start_mode: 0 = low, 1 = random, 2 = high.
  task automatic step(input int i, input logic [31:0] ir, input int w, input int start_mode);
    if (i == 2 + w) mem_ready = 1'b1;
    else if (i >= 2 && i < 2 + w) mem_ready = 1'b0;
    else mem_ready = 1'($urandom);
    ir_data = (i >= 3 + w) ? ir : $urandom;
    start = (start_mode == 2) ? 1'b1 : (start_mode == 1) ? 1'($urandom) : 1'b0;
    #1;
    check_obs("trace", i, cur, exp_q[i]);
    a_ro |= cur.ro; a_ri |= cur.ri; a_op |= cur.op;
    if (cur.done && a_done_at == 0) a_done_at = i + 1;
    if (cur.ill && a_ill_at == 0) a_ill_at = i + 1;
    if (cur.ctl & M_READ) a_read++;
    if (cur.ctl & M_PCIN) a_pc_in++;
    if (cur.ctl & M_LOIN) a_lo++;
    if (cur.ctl & M_HIIN) a_hi++;
    @(posedge Clock); #1;
  endtask

  task automatic idle_cycle();
    start = 1'b1; mem_ready = 1'($urandom); ir_data = $urandom;
    #1;
    check_obs("idle", 0, cur, '0);
    @(posedge Clock); #1;
  endtask

  task automatic run_instr(input logic [31:0] ir, input int w, input int start_mode);
    build_trace(ir, w);
    a_done_at = 0; a_ill_at = 0; a_read = 0; a_pc_in = 0; a_lo = 0; a_hi = 0;
    a_ro = '0; a_ri = '0; a_op = '0;
    idle_cycle();
    for (int i = 0; i < exp_q.size(); i++) step(i, ir, w, start_mode);
  endtask

  initial begin
    int legal_ops[13] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 15, 16, 17, 18};
    //          ir            w  done ill  ro       ri       op  rd pc lo hi
    vt[0] = '{32'h021B8000, 0, 7,  0, 16'h0088, 16'h0010, 0,  1, 1, 0, 0};
    vt[1] = '{32'h421B8000, 3, 10, 0, 16'h0088, 16'h0010, 8,  4, 1, 0, 0};
    vt[2] = '{32'h781B8000, 0, 8,  0, 16'h0088, 16'h0000, 15, 1, 1, 1, 1};
    vt[3] = '{32'h92900000, 0, 6,  0, 16'h0004, 16'h0020, 18, 1, 1, 0, 0};
    vt[4] = '{32'hF8000000, 0, 0,  5, 16'h0000, 16'h0000, 0,  1, 1, 0, 0};
    vt[5] = '{32'h08918000, 1, 8,  0, 16'h000C, 16'h0002, 1,  2, 1, 0, 0};
    vt[6] = '{32'h84F80000, 2, 10, 0, 16'h8001, 16'h0000, 16, 3, 1, 1, 1};
    vt[7] = '{32'h88700000, 0, 6,  0, 16'h4000, 16'h0001, 17, 1, 1, 0, 0};
    vt[8] = '{32'h48000000, 1, 0,  6, 16'h0000, 16'h0000, 0,  2, 1, 0, 0};

    clear = 1'b0; start = 1'b0; mem_ready = 1'b0; ir_data = '0;
    #3 check_obs("reset", 0, cur, '0);
    @(posedge Clock); #1;
    check_obs("reset_edge", 0, cur, '0);
    clear = 1'b1;
    @(posedge Clock); #1;

    for (int j = 0; j < 9; j++) begin
      run_instr(vt[j].ir, vt[j].w, 1);
      check_int("done_at", j, a_done_at, vt[j].done_at);
      check_int("ill_at", j, a_ill_at, vt[j].ill_at);
      check_int("reg_out_seen", j, int'(a_ro), int'(vt[j].ro));
      check_int("reg_in_seen", j, int'(a_ri), int'(vt[j].ri));
      check_int("alu_op_seen", j, int'(a_op), int'(vt[j].op));
      check_int("read_cycles", j, a_read, vt[j].n_read);
      check_int("pc_in_pulses", j, a_pc_in, vt[j].n_pc_in);
      check_int("lo_in_pulses", j, a_lo, vt[j].n_lo);
      check_int("hi_in_pulses", j, a_hi, vt[j].n_hi);
    end

    for (int j = 0; j < 40; j++) begin
      logic [4:0]  op;
      logic [31:0] ir;
      if ($urandom_range(0, 3) == 0) op = 5'($urandom_range(0, 31));
      else op = 5'(legal_ops[$urandom_range(0, 12)]);
      ir = {op, 27'($urandom)};
      run_instr(ir, int'($urandom_range(0, 3)), 1);
    end

    // Clear during T4 of an ADD, with a stray start pulse in T2.
    build_trace(32'h021B8000, 0);
    idle_cycle();
    for (int i = 0; i < 5; i++) step(i, 32'h021B8000, 0, (i == 3) ? 2 : 0);
    start = 1'b0; mem_ready = 1'b1; ir_data = 32'h021B8000;
    #1;
    check_obs("t4_before_clear", 5, cur, exp_q[5]);
    clear = 1'b0;
    #1;
    check_obs("clr_async", 0, cur, '0);
    @(posedge Clock); #1;
    check_obs("clr_hold", 0, cur, '0);
    clear = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge Clock); #1;
      check_obs("post_clr", i, cur, '0);
    end
    run_instr(32'h92900000, 1, 0);
    check_int("after_clr_done_at", 0, a_done_at, 7);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
